// File: rtl/pcf8591_i2c_responder.sv
// PCF8591 emulator on the I2C bus. It oversamples SCL/SDA, decodes START/STOP, matches the
// address, captures the control and DAC bytes on writes, and returns adc_value on reads.
module pcf8591_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h48
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] adc_value,
  output logic [7:0] dac_value,
  output logic       dac_valid,
  output logic [7:0] ctrl_byte,
  output logic       aout_en,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] BYTE_DONE = CNT_W'(BYTE_W);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_CTRL      = 4'd3,
    S_CTRL_ACK  = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [BYTE_W-1:0] r_shift;
  logic              r_rw;
  logic              r_drive;
  logic [BYTE_W-1:0] r_ctrl;
  logic [BYTE_W-1:0] r_dac;
  logic              r_dac_valid;
  logic              r_busy;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [BYTE_W-1:0] w_shift_nxt;
  logic              w_rw_nxt;
  logic              w_drive_nxt;
  logic [BYTE_W-1:0] w_ctrl_nxt;
  logic [BYTE_W-1:0] w_dac_nxt;
  logic              w_dac_valid_nxt;
  logic              w_busy_nxt;

  logic              w_scl_rise, w_scl_fall, w_start, w_stop;
  logic              w_last_bit;
  logic [BYTE_W-1:0] w_byte;

  // Bus conditions derived only from the synchronized copies of the pins
  assign w_scl_rise = r_scl_sync & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_sync & r_scl_prev;
  assign w_start    = r_scl_sync & r_sda_prev & ~r_sda_sync;
  assign w_stop     = r_scl_sync & ~r_sda_prev & r_sda_sync;
  assign w_last_bit = (r_cnt == LAST_BIT);
  assign w_byte     = {r_shift[BYTE_W-2:0], r_sda_sync};

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_scl_meta  <= 1'b1;
      r_scl_sync  <= 1'b1;
      r_scl_prev  <= 1'b1;
      r_sda_meta  <= 1'b1;
      r_sda_sync  <= 1'b1;
      r_sda_prev  <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_drive     <= 1'b0;
      r_ctrl      <= '0;
      r_dac       <= '0;
      r_dac_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_scl_meta  <= SCL;
      r_scl_sync  <= r_scl_meta;
      r_scl_prev  <= r_scl_sync;
      r_sda_meta  <= SDA;
      r_sda_sync  <= r_sda_meta;
      r_sda_prev  <= r_sda_sync;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rw        <= w_rw_nxt;
      r_drive     <= w_drive_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_dac       <= w_dac_nxt;
      r_dac_valid <= w_dac_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_rw_nxt        = r_rw;
    w_drive_nxt     = r_drive;
    w_ctrl_nxt      = r_ctrl;
    w_dac_nxt       = r_dac;
    w_dac_valid_nxt = 1'b0;
    w_busy_nxt      = r_busy;

    if (w_start) begin
      w_busy_nxt = 1'b1;
    end else if (w_stop) begin
      w_busy_nxt = 1'b0;
    end

    // START/STOP override everything, dropping any partial byte
    if (w_start) begin
      w_state_nxt = S_ADDR;
      w_cnt_nxt   = '0;
      w_drive_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_drive_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_IGNORE: begin
          w_drive_nxt = 1'b0;
        end

        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (w_last_bit) begin
              w_rw_nxt    = r_sda_sync;
              w_state_nxt = (w_byte[BYTE_W-1:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
            end
          end
        end

        // First falling edge starts the ACK, the second ends it
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_drive) begin
              w_drive_nxt = 1'b1;
            end else begin
              w_cnt_nxt = '0;
              if (r_rw) begin
                w_state_nxt = S_RDATA;
                w_drive_nxt = ~adc_value[BYTE_W-1];
                w_shift_nxt = {adc_value[BYTE_W-2:0], 1'b0};
              end else begin
                w_state_nxt = S_CTRL;
                w_drive_nxt = 1'b0;
              end
            end
          end
        end

        S_CTRL: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (w_last_bit) begin
              w_ctrl_nxt  = w_byte;
              w_state_nxt = S_CTRL_ACK;
            end
          end
        end

        S_CTRL_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_drive) begin
              w_drive_nxt = 1'b1;
            end else begin
              w_drive_nxt = 1'b0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_WDATA;
            end
          end
        end

        S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (w_last_bit) begin
              w_dac_nxt       = w_byte;
              w_dac_valid_nxt = 1'b1;
              w_state_nxt     = S_WDATA_ACK;
            end
          end
        end

        // Shift register holds the bits still to be presented, MSB at the top
        S_RDATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else if (w_scl_fall) begin
            if (r_cnt == BYTE_DONE) begin
              w_drive_nxt = 1'b0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_RDATA_ACK;
            end else begin
              w_drive_nxt = ~r_shift[BYTE_W-1];
              w_shift_nxt = {r_shift[BYTE_W-2:0], 1'b0};
            end
          end
        end

        S_RDATA_ACK: begin
          w_drive_nxt = 1'b0;
          if (w_scl_rise) begin
            if (!r_sda_sync) begin
              w_state_nxt = S_RDATA;
              w_cnt_nxt   = '0;
              w_shift_nxt = adc_value;
            end else begin
              w_state_nxt = S_IGNORE;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_drive_nxt = 1'b0;
        end
      endcase
    end
  end

  assign SDA       = r_drive ? 1'b0 : 1'bz;
  assign dac_value = r_dac;
  assign dac_valid = r_dac_valid;
  assign ctrl_byte = r_ctrl;
  assign aout_en   = r_ctrl[6];
  assign busy      = r_busy;

endmodule

// File: tb/tb_pcf8591_i2c_responder.sv
// Bench for pcf8591_i2c_responder: an I2C initiator model drives SCL/SDA and a
// transaction-level model of the PCF8591 predicts ACKs, captured bytes and read data.
module tb_pcf8591_i2c_responder;

  logic       clk = 1'b0;
  logic       resetN;
  logic       scl;
  logic       m_sda_low;
  wire        sda_bus;
  logic [7:0] adc_value;
  logic [7:0] dac_value;
  logic [7:0] ctrl_byte;
  logic       dac_valid;
  logic       aout_en;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_pulses = 0;
  int valid_cycles = 0;
  logic valid_prev = 1'b0;

  logic [7:0] m_ctrl = 8'h00;
  logic [7:0] m_dac  = 8'h00;
  logic [7:0] tx [8];

  always #5 clk = ~clk;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  pcf8591_i2c_responder dut (
    .clk       (clk),
    .resetN    (resetN),
    .SCL       (scl),
    .SDA       (sda_bus),
    .adc_value (adc_value),
    .dac_value (dac_value),
    .dac_valid (dac_valid),
    .ctrl_byte (ctrl_byte),
    .aout_en   (aout_en),
    .busy      (busy)
  );

  always @(negedge clk) begin
    valid_prev <= dac_valid;
    if (dac_valid) valid_cycles <= valid_cycles + 1;
    if (dac_valid && !valid_prev) valid_pulses <= valid_pulses + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period starting just after SCL fell; samples the bus mid-high
  task automatic bit_cycle(input logic low, output logic sampled);
    tick(4); m_sda_low = low;
    tick(4); scl = 1'b1;
    tick(4); sampled = sda_bus;
    tick(4); scl = 1'b0;
  endtask

  task automatic i2c_start();
    tick(4); m_sda_low = 1'b1;
    tick(8); scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    tick(4); m_sda_low = 1'b0;
    tick(4); scl = 1'b1;
    tick(4); m_sda_low = 1'b1;
    tick(8); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(4); m_sda_low = 1'b1;
    tick(4); scl = 1'b1;
    tick(4); m_sda_low = 1'b0;
    tick(12);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(~b[i], s);
    bit_cycle(1'b0, s);
    acked = (s === 1'b0);
  endtask

  task automatic read_bits(output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b0, s);
      b = {b[6:0], s};
    end
  endtask

  task automatic write_txn(input logic [6:0] a, input int n, output int n_ack, output logic busy_mid);
    logic ack;
    n_ack = 0;
    i2c_start();
    busy_mid = busy;
    write_byte({a, 1'b0}, ack);
    if (ack) n_ack++;
    for (int k = 0; k < n; k++) begin
      write_byte(tx[k], ack);
      if (ack) n_ack++;
    end
    i2c_stop();
  endtask

  // Transaction-level expectation for a write
  task automatic model_write(input logic [6:0] a, input int n);
    if (a == 7'h48 && n >= 1) begin
      m_ctrl = tx[0];
      if (n >= 2) m_dac = tx[n-1];
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0; scl = 1'b1; m_sda_low = 1'b0; adc_value = 8'h00;
    tick(5);
    n_checks++; if (dac_value !== 8'h00) begin n_fail++; $display("FAIL reset_dac got=%h exp=00", dac_value); end
    n_checks++; if (ctrl_byte !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=00", ctrl_byte); end
    n_checks++; if (aout_en !== 1'b0) begin n_fail++; $display("FAIL reset_aout got=%b exp=0", aout_en); end
    n_checks++; if (dac_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", dac_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL reset_sda got=%b exp=1", sda_bus); end
    resetN = 1'b1;
    tick(10);
  endtask

  task automatic test_basic_write();
    int n_ack; logic bm; int p0;
    p0 = valid_pulses;
    tx[0] = 8'h40; tx[1] = 8'hA5;
    write_txn(7'h48, 2, n_ack, bm);
    model_write(7'h48, 2);
    n_checks++; if (n_ack != 3) begin n_fail++; $display("FAIL basic_acks got=%0d exp=3", n_ack); end
    n_checks++; if (bm !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid got=%b exp=1", bm); end
    n_checks++; if (ctrl_byte !== 8'h40) begin n_fail++; $display("FAIL basic_ctrl got=%h exp=40", ctrl_byte); end
    n_checks++; if (aout_en !== 1'b1) begin n_fail++; $display("FAIL basic_aout got=%b exp=1", aout_en); end
    n_checks++; if (dac_value !== 8'hA5) begin n_fail++; $display("FAIL basic_dac got=%h exp=a5", dac_value); end
    n_checks++; if (valid_pulses - p0 != 1) begin n_fail++; $display("FAIL basic_pulses got=%0d exp=1", valid_pulses - p0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_wrong_addr();
    int n_ack; logic bm; int p0; logic [6:0] a;
    for (int it = 0; it < 4; it++) begin
      a = (it == 0) ? 7'h49 : 7'($urandom);
      if (a == 7'h48) a = 7'h4C;
      tx[0] = 8'($urandom); tx[1] = 8'($urandom); tx[2] = 8'($urandom);
      p0 = valid_pulses;
      write_txn(a, 3, n_ack, bm);
      model_write(a, 3);
      n_checks++; if (n_ack != 0) begin n_fail++; $display("FAIL nack_acks addr=%h got=%0d exp=0", a, n_ack); end
      n_checks++; if (ctrl_byte !== m_ctrl) begin n_fail++; $display("FAIL nack_ctrl got=%h exp=%h", ctrl_byte, m_ctrl); end
      n_checks++; if (dac_value !== m_dac) begin n_fail++; $display("FAIL nack_dac got=%h exp=%h", dac_value, m_dac); end
      n_checks++; if (valid_pulses != p0) begin n_fail++; $display("FAIL nack_pulses got=%0d exp=0", valid_pulses - p0); end
    end
  endtask

  task automatic test_burst();
    int n_ack; logic bm; int p0; int n;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        n = 4; tx[0] = 8'h40; tx[1] = 8'h10; tx[2] = 8'h20; tx[3] = 8'h30;
      end else begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) tx[k] = 8'($urandom);
      end
      p0 = valid_pulses;
      write_txn(7'h48, n, n_ack, bm);
      model_write(7'h48, n);
      n_checks++; if (n_ack != n + 1) begin n_fail++; $display("FAIL burst_acks got=%0d exp=%0d", n_ack, n + 1); end
      n_checks++; if (valid_pulses - p0 != n - 1) begin n_fail++; $display("FAIL burst_pulses got=%0d exp=%0d", valid_pulses - p0, n - 1); end
      n_checks++; if (dac_value !== m_dac) begin n_fail++; $display("FAIL burst_dac got=%h exp=%h", dac_value, m_dac); end
      n_checks++; if (ctrl_byte !== m_ctrl) begin n_fail++; $display("FAIL burst_ctrl got=%h exp=%h", ctrl_byte, m_ctrl); end
      n_checks++; if (aout_en !== m_ctrl[6]) begin n_fail++; $display("FAIL burst_aout got=%b exp=%b", aout_en, m_ctrl[6]); end
    end
  endtask

  task automatic test_read();
    logic ack; logic s; logic [7:0] b; logic [7:0] exp; int n;
    for (int it = 0; it < 4; it++) begin
      n   = (it == 0) ? 2 : $urandom_range(1, 4);
      exp = (it == 0) ? 8'h3C : 8'($urandom);
      adc_value = exp;
      i2c_start();
      write_byte(8'h91, ack);
      n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack got=%b exp=1", ack); end
      for (int k = 0; k < n; k++) begin
        read_bits(b);
        n_checks++; if (b !== exp) begin n_fail++; $display("FAIL read_data byte=%0d got=%h exp=%h", k, b, exp); end
        if (k < n - 1) begin
          if (it != 0) exp = 8'($urandom);
          adc_value = exp;
          bit_cycle(1'b1, s);
        end else begin
          bit_cycle(1'b0, s);
        end
      end
      read_bits(b);
      n_checks++; if (b !== 8'hFF) begin n_fail++; $display("FAIL read_after_nack got=%h exp=ff", b); end
      bit_cycle(1'b0, s);
      n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL read_after_nack_ack got=%b exp=1", s); end
      i2c_stop();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_end got=%b exp=0", busy); end
    end
  endtask

  task automatic test_partial();
    logic ack; logic s; int p0; int n_good;
    p0 = valid_pulses;
    n_good = 0;
    i2c_start();
    write_byte(8'h90, ack); if (ack) n_good++;
    write_byte(8'h40, ack); if (ack) n_good++;
    bit_cycle(1'b0, s); bit_cycle(1'b1, s); bit_cycle(1'b0, s); bit_cycle(1'b0, s);
    i2c_rstart();
    write_byte(8'h90, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rstart_addr_ack got=%b exp=1", ack); end
    n_checks++; if (valid_pulses != p0) begin n_fail++; $display("FAIL rstart_pulses got=%0d exp=0", valid_pulses - p0); end
    n_checks++; if (dac_value !== m_dac) begin n_fail++; $display("FAIL rstart_dac got=%h exp=%h", dac_value, m_dac); end
    write_byte(8'h05, ack); if (ack) n_good++;
    i2c_stop();
    m_ctrl = 8'h05;
    n_checks++; if (n_good != 3) begin n_fail++; $display("FAIL rstart_acks got=%0d exp=3", n_good); end
    n_checks++; if (ctrl_byte !== m_ctrl) begin n_fail++; $display("FAIL rstart_ctrl got=%h exp=%h", ctrl_byte, m_ctrl); end
    // STOP in the middle of a data byte
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h11, ack);
    for (int i = 0; i < 5; i++) bit_cycle(1'($urandom), s);
    i2c_stop();
    m_ctrl = 8'h11;
    n_checks++; if (valid_pulses != p0) begin n_fail++; $display("FAIL stop_mid_pulses got=%0d exp=0", valid_pulses - p0); end
    n_checks++; if (dac_value !== m_dac) begin n_fail++; $display("FAIL stop_mid_dac got=%h exp=%h", dac_value, m_dac); end
    n_checks++; if (ctrl_byte !== m_ctrl) begin n_fail++; $display("FAIL stop_mid_ctrl got=%h exp=%h", ctrl_byte, m_ctrl); end
  endtask

  task automatic test_reset_mid_ack();
    logic s; int n_ack; logic bm; int p0;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_cycle(~(8'h90 >> i) & 1'b1, s);
    tick(4); m_sda_low = 1'b0;
    tick(4); scl = 1'b1;
    tick(2);
    n_checks++; if (sda_bus !== 1'b0) begin n_fail++; $display("FAIL rst_ack_driving got=%b exp=0", sda_bus); end
    resetN = 1'b0;
    tick(1);
    n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL rst_sda_release got=%b exp=1", sda_bus); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_checks++; if (ctrl_byte !== 8'h00) begin n_fail++; $display("FAIL rst_ctrl got=%h exp=00", ctrl_byte); end
    n_checks++; if (dac_value !== 8'h00) begin n_fail++; $display("FAIL rst_dac got=%h exp=00", dac_value); end
    n_checks++; if (aout_en !== 1'b0) begin n_fail++; $display("FAIL rst_aout got=%b exp=0", aout_en); end
    m_ctrl = 8'h00; m_dac = 8'h00;
    tick(3);
    resetN = 1'b1;
    tick(10);
    p0 = valid_pulses;
    tx[0] = 8'h40; tx[1] = 8'h5A;
    write_txn(7'h48, 2, n_ack, bm);
    model_write(7'h48, 2);
    n_checks++; if (n_ack != 3) begin n_fail++; $display("FAIL post_rst_acks got=%0d exp=3", n_ack); end
    n_checks++; if (dac_value !== m_dac) begin n_fail++; $display("FAIL post_rst_dac got=%h exp=%h", dac_value, m_dac); end
    n_checks++; if (ctrl_byte !== m_ctrl) begin n_fail++; $display("FAIL post_rst_ctrl got=%h exp=%h", ctrl_byte, m_ctrl); end
    n_checks++; if (valid_pulses - p0 != 1) begin n_fail++; $display("FAIL post_rst_pulses got=%0d exp=1", valid_pulses - p0); end
  endtask

  initial begin
    resetN = 1'b0; scl = 1'b1; m_sda_low = 1'b0; adc_value = 8'h00;
    test_reset();
    test_basic_write();
    test_wrong_addr();
    test_burst();
    test_read();
    test_partial();
    test_reset_mid_ack();
    tick(4);
    n_checks++; if (valid_cycles != valid_pulses) begin n_fail++; $display("FAIL valid_width high_cycles=%0d pulses=%0d", valid_cycles, valid_pulses); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
